// File: rtl/id_ex_pipe_reg.sv
// ID->EX pipeline register.
// Captures the decoded operands, immediate, instruction and ALU op, and
// registers the M/WB control bundles decoded from the op code. Adds a valid
// bit plus stall (hold) and flush (bubble). Priority is rst > flush > stall > load.
// Optional macro ID_EX_PERF_CNT_EN adds saturating stall and bubble counters.
// With the macro undefined, both counter outputs are tied to zero.
module id_ex_pipe_reg #(
    parameter int XLEN      = 32,
    parameter int ILEN      = 32,   // must be >= 25 so that instr[24:20] exists
    parameter int OP_W      = 4,
    parameter int REG_IDX_W = 5,
    parameter int CNT_W     = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 stall_i,
    input  logic                 flush_i,
    input  logic                 valid_i,
    input  logic [XLEN-1:0]      pc_i,
    input  logic [XLEN-1:0]      rs1_data_i,
    input  logic [XLEN-1:0]      rs2_data_i,
    input  logic [XLEN-1:0]      imm_i,
    input  logic [ILEN-1:0]      instr_i,
    input  logic [OP_W-1:0]      op_i,
    input  logic                 alu_src_i,
    output logic                 valid_o,
    output logic [XLEN-1:0]      pc_o,
    output logic [XLEN-1:0]      rs1_data_o,
    output logic [XLEN-1:0]      rs2_data_o,
    output logic [XLEN-1:0]      imm_o,
    output logic [ILEN-1:0]      instr_o,
    output logic [OP_W-1:0]      op_o,
    output logic                 alu_src_o,
    output logic [REG_IDX_W-1:0] rs1_idx_o,
    output logic [REG_IDX_W-1:0] rs2_idx_o,
    output logic [REG_IDX_W-1:0] rd_idx_o,
    output logic [2:0]           mem_ctrl_o,
    output logic [1:0]           wb_ctrl_o,
    output logic [CNT_W-1:0]     stall_cnt_o,
    output logic [CNT_W-1:0]     bubble_cnt_o
);

    // Register index fields are sliced from the incoming instruction.
    // They are never derived from instr_o.
    logic [REG_IDX_W-1:0] w_rs1_idx;
    logic [REG_IDX_W-1:0] w_rs2_idx;
    logic [REG_IDX_W-1:0] w_rd_idx;
    logic [2:0]           w_mem_ctrl;   // {mem_read, mem_write, branch}
    logic [1:0]           w_wb_ctrl;    // {mem_to_reg, reg_write}
    logic                 w_load;

    assign w_rs1_idx = instr_i[15 +: REG_IDX_W];
    assign w_rs2_idx = instr_i[20 +: REG_IDX_W];
    assign w_rd_idx  = instr_i[7  +: REG_IDX_W];
    assign w_load    = !flush_i && !stall_i;

    // Decode the control bundles from the op code. An empty slot carries no side effects.
    always_comb begin
        w_mem_ctrl = 3'b000;
        w_wb_ctrl  = 2'b00;
        if (valid_i) begin
            case (op_i)
                OP_W'(4'b0000), OP_W'(4'b0001), OP_W'(4'b0010),
                OP_W'(4'b0011), OP_W'(4'b0100), OP_W'(4'b1000): begin
                    w_mem_ctrl = 3'b000;
                    w_wb_ctrl  = 2'b01;
                end
                OP_W'(4'b0101): begin   // ld
                    w_mem_ctrl = 3'b100;
                    w_wb_ctrl  = 2'b11;
                end
                OP_W'(4'b0110): begin   // sd
                    w_mem_ctrl = 3'b010;
                    w_wb_ctrl  = 2'b00;
                end
                OP_W'(4'b0111): begin   // beq
                    w_mem_ctrl = 3'b001;
                    w_wb_ctrl  = 2'b00;
                end
                default: begin
                    w_mem_ctrl = 3'b000;
                    w_wb_ctrl  = 2'b00;
                end
            endcase
        end
    end

    // Control fields: a flush clears them, a stall holds them, and otherwise they load.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_o    <= 1'b0;
            op_o       <= '0;
            alu_src_o  <= 1'b0;
            mem_ctrl_o <= 3'b000;
            wb_ctrl_o  <= 2'b00;
        end else if (flush_i) begin
            valid_o    <= 1'b0;
            op_o       <= '0;
            alu_src_o  <= 1'b0;
            mem_ctrl_o <= 3'b000;
            wb_ctrl_o  <= 2'b00;
        end else if (!stall_i) begin
            valid_o    <= valid_i;
            op_o       <= op_i;
            alu_src_o  <= alu_src_i;
            mem_ctrl_o <= w_mem_ctrl;
            wb_ctrl_o  <= w_wb_ctrl;
        end
    end

    // Data and index fields load only when neither flush nor stall is asserted.
    // A bubble leaves stale data behind, but the cleared controls make it inert.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc_o       <= '0;
            rs1_data_o <= '0;
            rs2_data_o <= '0;
            imm_o      <= '0;
            instr_o    <= '0;
            rs1_idx_o  <= '0;
            rs2_idx_o  <= '0;
            rd_idx_o   <= '0;
        end else if (w_load) begin
            pc_o       <= pc_i;
            rs1_data_o <= rs1_data_i;
            rs2_data_o <= rs2_data_i;
            imm_o      <= imm_i;
            instr_o    <= instr_i;
            rs1_idx_o  <= w_rs1_idx;
            rs2_idx_o  <= w_rs2_idx;
            rd_idx_o   <= w_rd_idx;
        end
    end

`ifdef ID_EX_PERF_CNT_EN
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_bubble_cnt;
    logic             w_stall_evt;
    logic             w_bubble_evt;

    assign w_stall_evt  = stall_i && !flush_i;
    assign w_bubble_evt = flush_i || (!stall_i && !valid_i);

    // Saturating event counters that stop at all-ones and never wrap.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
        end else begin
            if (w_stall_evt && (r_stall_cnt != {CNT_W{1'b1}}))
                r_stall_cnt <= r_stall_cnt + 1'b1;
            if (w_bubble_evt && (r_bubble_cnt != {CNT_W{1'b1}}))
                r_bubble_cnt <= r_bubble_cnt + 1'b1;
        end
    end

    assign stall_cnt_o  = r_stall_cnt;
    assign bubble_cnt_o = r_bubble_cnt;
`else
    assign stall_cnt_o  = '0;
    assign bubble_cnt_o = '0;
`endif

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Directed bench for id_ex_pipe_reg. It uses CNT_W=4 so that counter saturation is reachable.
module tb_id_ex_pipe_reg;
    localparam int XLEN = 32;
    localparam int ILEN = 32;
    localparam int OP_W = 4;
    localparam int RW   = 5;
    localparam int CW   = 4;

`ifdef ID_EX_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic            clk_i = 1'b0;
    logic            rst_i, stall_i, flush_i, valid_i, alu_src_i;
    logic [XLEN-1:0] pc_i, rs1_data_i, rs2_data_i, imm_i;
    logic [ILEN-1:0] instr_i;
    logic [OP_W-1:0] op_i;
    logic            valid_o, alu_src_o;
    logic [XLEN-1:0] pc_o, rs1_data_o, rs2_data_o, imm_o;
    logic [ILEN-1:0] instr_o;
    logic [OP_W-1:0] op_o;
    logic [RW-1:0]   rs1_idx_o, rs2_idx_o, rd_idx_o;
    logic [2:0]      mem_ctrl_o;
    logic [1:0]      wb_ctrl_o;
    logic [CW-1:0]   stall_cnt_o, bubble_cnt_o;

    int vecs = 0;
    int errs = 0;

    id_ex_pipe_reg #(.XLEN(XLEN), .ILEN(ILEN), .OP_W(OP_W), .REG_IDX_W(RW), .CNT_W(CW)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i),
        .valid_i(valid_i), .pc_i(pc_i), .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i),
        .imm_i(imm_i), .instr_i(instr_i), .op_i(op_i), .alu_src_i(alu_src_i),
        .valid_o(valid_o), .pc_o(pc_o), .rs1_data_o(rs1_data_o), .rs2_data_o(rs2_data_o),
        .imm_o(imm_o), .instr_o(instr_o), .op_o(op_o), .alu_src_o(alu_src_o),
        .rs1_idx_o(rs1_idx_o), .rs2_idx_o(rs2_idx_o), .rd_idx_o(rd_idx_o),
        .mem_ctrl_o(mem_ctrl_o), .wb_ctrl_o(wb_ctrl_o),
        .stall_cnt_o(stall_cnt_o), .bubble_cnt_o(bubble_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Apply one rising edge, then settle before sampling.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic v, input logic [OP_W-1:0] op, input logic [ILEN-1:0] ins,
                         input logic [XLEN-1:0] pc);
        valid_i    = v;
        op_i       = op;
        instr_i    = ins;
        pc_i       = pc;
        rs1_data_i = pc + 32'h11;
        rs2_data_i = pc + 32'h22;
        imm_i      = pc + 32'h33;
        alu_src_i  = op[0];
    endtask

    // Pulse reset away from the clock edge and leave the inputs quiet.
    task automatic do_reset();
        #2 rst_i = 1'b1;
        stall_i = 1'b0;
        flush_i = 1'b0;
        #2 rst_i = 1'b0;
    endtask

    initial begin
        rst_i = 1'b1; stall_i = 1'b0; flush_i = 1'b0;
        drive(1'b0, 4'h0, 32'h0, 32'h0);
        #3;
        // Reset state
        chk("rst_valid", valid_o, 0);
        chk("rst_pc", pc_o, 0);
        chk("rst_ctrl", {mem_ctrl_o, wb_ctrl_o}, 0);
        chk("rst_cnt", {stall_cnt_o, bubble_cnt_o}, 0);
        #2 rst_i = 1'b0;

        // 1. ld decode and index slicing
        drive(1'b1, 4'b0101, 32'h00A13283, 32'h1000);
        tick();
        chk("ld_valid", valid_o, 1);
        chk("ld_M", mem_ctrl_o, 3'b100);
        chk("ld_WB", wb_ctrl_o, 2'b11);
        chk("ld_rd", rd_idx_o, 5);
        chk("ld_rs1", rs1_idx_o, 2);
        chk("ld_rs2", rs2_idx_o, 10);
        chk("ld_pc", pc_o, 32'h1000);
        chk("ld_imm", imm_o, 32'h1033);
        chk("ld_instr", instr_o, 32'h00A13283);

        // 2. add load, then a 3-edge stall while the inputs change
        do_reset();
        drive(1'b1, 4'b0010, 32'h003100B3, 32'h2000);  // rd=1 rs1=2 rs2=3
        tick();
        chk("add_WB", wb_ctrl_o, 2'b01);
        stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 4'b0101, 32'hFFFFFFFF, 32'h3000 + i);
            tick();
        end
        chk("stl_pc", pc_o, 32'h2000);
        chk("stl_op", op_o, 4'b0010);
        chk("stl_ctrl", {mem_ctrl_o, wb_ctrl_o}, 5'b000_01);
        chk("stl_idx", {rd_idx_o, rs1_idx_o, rs2_idx_o}, {5'd1, 5'd2, 5'd3});
        chk("stl_valid", valid_o, 1);
        chk("stl_cnt", stall_cnt_o, PERF ? 3 : 0);
        chk("stl_bub", bubble_cnt_o, 0);

        // 3. sd load, then flush together with stall
        do_reset();
        drive(1'b1, 4'b0110, 32'h00A13283, 32'h4000);
        tick();
        chk("sd_M", mem_ctrl_o, 3'b010);
        chk("sd_WB", wb_ctrl_o, 2'b00);
        flush_i = 1'b1; stall_i = 1'b1;
        drive(1'b1, 4'b0101, 32'h0, 32'h5000);
        tick();
        flush_i = 1'b0; stall_i = 1'b0;
        chk("fl_valid", valid_o, 0);
        chk("fl_ctrl", {mem_ctrl_o, wb_ctrl_o}, 0);
        chk("fl_op", op_o, 0);
        chk("fl_alusrc", alu_src_o, 0);
        chk("fl_pc", pc_o, 32'h4000);
        chk("fl_rd", rd_idx_o, 5);
        chk("fl_bub", bubble_cnt_o, PERF ? 1 : 0);
        chk("fl_stl", stall_cnt_o, 0);

        // 4. Asynchronous reset asserted mid-stall, between edges
        drive(1'b1, 4'b0101, 32'h00A13283, 32'h6000);
        tick();
        stall_i = 1'b1;
        tick();
        #2 rst_i = 1'b1;
        #1;
        chk("ar_valid", valid_o, 0);
        chk("ar_pc", pc_o, 0);
        chk("ar_ctrl", {mem_ctrl_o, wb_ctrl_o}, 0);
        chk("ar_idx", {rd_idx_o, rs1_idx_o, rs2_idx_o}, 0);
        chk("ar_cnt", {stall_cnt_o, bubble_cnt_o}, 0);
        rst_i = 1'b0; stall_i = 1'b0;
        drive(1'b1, 4'b0111, 32'h00A13283, 32'h7000);
        tick();
        chk("ar_beq_M", mem_ctrl_o, 3'b001);
        chk("ar_beq_pc", pc_o, 32'h7000);
        chk("ar_beq_v", valid_o, 1);

        // 5. Invalid slot and undefined op
        do_reset();
        drive(1'b0, 4'b0101, 32'h00A13283, 32'h8000);
        tick();
        chk("inv_ctrl", {mem_ctrl_o, wb_ctrl_o}, 0);
        chk("inv_valid", valid_o, 0);
        chk("inv_pc", pc_o, 32'h8000);
        chk("inv_bub", bubble_cnt_o, PERF ? 1 : 0);
        drive(1'b1, 4'b1111, 32'h00A13283, 32'h8100);
        tick();
        chk("undef_ctrl", {mem_ctrl_o, wb_ctrl_o}, 0);
        chk("undef_valid", valid_o, 1);
        drive(1'b1, 4'b1000, 32'h00A13283, 32'h8200);
        tick();
        chk("op8_ctrl", {mem_ctrl_o, wb_ctrl_o}, 5'b000_01);

        // 6. Stall counter saturates at 15 with CNT_W=4
        do_reset();
        stall_i = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        chk("sat_stl", stall_cnt_o, PERF ? 15 : 0);
        stall_i = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    // Guard against a hang.
    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
